// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: branch funct3 encodings, BHT counter states, legality helper.
package branch_predictor_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        RSV2 = 3'b010,
        RSV3 = 3'b011,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_funct3_t;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_RESET = WNT;

    // funct3 010/011 are not conditional branches; such updates must leave all state untouched.
    function automatic logic is_branch_op(branch_funct3_t op);
        return !((op == RSV2) || (op == RSV3));
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction request/response, execute-side resolution feedback and perf counters.
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    logic           pred_req;
    logic [31:0]    pred_pc;
    logic           pred_valid;
    logic           pred_taken;
    logic           pred_hit;
    logic [31:0]    pred_target;

    logic           upd_valid;
    logic [31:0]    upd_pc;
    branch_funct3_t upd_cmpop;
    logic           upd_taken;
    logic [31:0]    upd_target;
    logic           upd_pred_taken;

    logic [31:0]    perf_branches;
    logic [31:0]    perf_mispredicts;

    modport master (
        output pred_req, pred_pc,
        output upd_valid, upd_pc, upd_cmpop, upd_taken, upd_target, upd_pred_taken,
        input  pred_valid, pred_taken, pred_hit, pred_target,
        input  perf_branches, perf_mispredicts
    );

    modport slave (
        input  pred_req, pred_pc,
        input  upd_valid, upd_pc, upd_cmpop, upd_taken, upd_target, upd_pred_taken,
        output pred_valid, pred_taken, pred_hit, pred_target,
        output perf_branches, perf_mispredicts
    );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter next-state block; combinational, zero latency.
// No backpressure: inc and dec together (or neither) hold the state.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  bht_state_t state,
    input  logic       inc,
    input  logic       dec,
    output bht_state_t next
);

    logic [1:0] cur;

    assign cur = state;

    always_comb begin
        next = state;
        if (inc && !dec && (state != ST)) begin
            next = bht_state_t'(cur + 2'd1);
        end else if (dec && !inc && (state != SNT)) begin
            next = bht_state_t'(cur - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal/gshare (GSHARE_EN) BHT + tagged BTB predictor; prediction 1 cycle after pred_req, update-to-predict bypass.
// No backpressure: predict and update are both accepted every cycle.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);

    localparam int ENTRIES = 1 << IDX_BITS;

    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0] tag_t;

    bht_state_t          bht        [ENTRIES];
    logic [ENTRIES-1:0]  btb_valid;
    tag_t                btb_tag    [ENTRIES];
    logic [31:0]         btb_target [ENTRIES];

    idx_t        pred_idx, upd_idx, pred_bidx, upd_bidx;
    tag_t        pred_tag, upd_tag;
    logic        upd_legal, upd_alloc;
    bht_state_t  upd_ctr_cur, upd_ctr_next, pred_ctr;
    logic        lk_valid, lk_hit;
    tag_t        lk_tag;
    logic [31:0] lk_target;

    logic        pred_valid_q, pred_taken_q, pred_hit_q;
    logic [31:0] pred_target_q, perf_branches_q, perf_mispredicts_q;

    assign pred_idx  = bp.pred_pc[IDX_BITS+1:2];
    assign pred_tag  = bp.pred_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign upd_idx   = bp.upd_pc[IDX_BITS+1:2];
    assign upd_tag   = bp.upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign upd_legal = bp.upd_valid && is_branch_op(bp.upd_cmpop);
    assign upd_alloc = upd_legal && bp.upd_taken;

`ifdef GSHARE_EN
    idx_t ghr;

    // Both sides hash with the pre-shift history, so a same-cycle update and predict agree on the index.
    assign pred_bidx = pred_idx ^ ghr;
    assign upd_bidx  = upd_idx ^ ghr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (upd_legal) begin
            ghr <= {ghr[IDX_BITS-2:0], bp.upd_taken};
        end
    end
`else
    assign pred_bidx = pred_idx;
    assign upd_bidx  = upd_idx;
`endif

    assign upd_ctr_cur = bht[upd_bidx];

    sat_counter2 u_ctr (
        .state (upd_ctr_cur),
        .inc   (bp.upd_taken),
        .dec   (!bp.upd_taken),
        .next  (upd_ctr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= BHT_RESET;
            end
        end else if (upd_legal) begin
            bht[upd_bidx] <= upd_ctr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid <= '0;
        end else if (upd_alloc) begin
            btb_valid[upd_idx] <= 1'b1;
        end
    end

    // Tag/target payload is only meaningful behind btb_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (upd_alloc) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= bp.upd_target;
        end
    end

    // Write-first view of the tables for the predict lookup.
    always_comb begin
        pred_ctr  = bht[pred_bidx];
        lk_valid  = btb_valid[pred_idx];
        lk_tag    = btb_tag[pred_idx];
        lk_target = btb_target[pred_idx];
        if (upd_legal && (upd_bidx == pred_bidx)) begin
            pred_ctr = upd_ctr_next;
        end
        if (upd_alloc && (upd_idx == pred_idx)) begin
            lk_valid  = 1'b1;
            lk_tag    = upd_tag;
            lk_target = bp.upd_target;
        end
        lk_hit = lk_valid && (lk_tag == pred_tag);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q <= bp.pred_req;
            if (bp.pred_req) begin
                pred_hit_q    <= lk_hit;
                pred_taken_q  <= lk_hit && pred_ctr[1];
                pred_target_q <= lk_hit ? lk_target : 32'h0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else if (upd_legal) begin
            if (perf_branches_q != 32'hFFFF_FFFF) begin
                perf_branches_q <= perf_branches_q + 32'd1;
            end
            if ((bp.upd_taken != bp.upd_pred_taken) && (perf_mispredicts_q != 32'hFFFF_FFFF)) begin
                perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
            end
        end
    end

    assign bp.pred_valid       = pred_valid_q;
    assign bp.pred_taken       = pred_taken_q;
    assign bp.pred_hit         = pred_hit_q;
    assign bp.pred_target      = pred_target_q;
    assign bp.perf_branches    = perf_branches_q;
    assign bp.perf_mispredicts = perf_mispredicts_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pred_pc[31:IDX_BITS+TAG_BITS+2], bp.pred_pc[1:0],
                              bp.upd_pc[31:IDX_BITS+TAG_BITS+2], bp.upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Vector table plus hand sequences; predictions checked through an expected-result queue.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_predictor_if bp ();

    branch_predictor #(.IDX_BITS(6), .TAG_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    typedef struct {
        logic        req;
        logic [31:0] ppc;
        logic        uv;
        logic [31:0] upc;
        logic [2:0]  op;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic        e_taken;
        logic        e_hit;
        logic [31:0] e_tgt;
    } vec_t;

    typedef struct packed {
        logic        taken;
        logic        hit;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t v(logic req, logic [31:0] ppc, logic uv, logic [31:0] upc,
                               logic [2:0] op, logic ut, logic [31:0] utgt, logic upt,
                               logic et, logic eh, logic [31:0] etgt);
        vec_t r;
        r.req = req; r.ppc = ppc; r.uv = uv; r.upc = upc; r.op = op; r.ut = ut;
        r.utgt = utgt; r.upt = upt; r.e_taken = et; r.e_hit = eh; r.e_tgt = etgt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bp.pred_req       = 1'b0;
        bp.pred_pc        = '0;
        bp.upd_valid      = 1'b0;
        bp.upd_pc         = '0;
        bp.upd_cmpop      = BEQ;
        bp.upd_taken      = 1'b0;
        bp.upd_target     = '0;
        bp.upd_pred_taken = 1'b0;
    endtask

    // Drive one cycle of stimulus, then check the registered outputs just after the edge.
    task automatic step(input vec_t t, input string name);
        exp_t e;
        bp.pred_req       = t.req;
        bp.pred_pc        = t.ppc;
        bp.upd_valid      = t.uv;
        bp.upd_pc         = t.upc;
        bp.upd_cmpop      = branch_funct3_t'(t.op);
        bp.upd_taken      = t.ut;
        bp.upd_target     = t.utgt;
        bp.upd_pred_taken = t.upt;
        if (t.req) sb.push_back('{taken: t.e_taken, hit: t.e_hit, tgt: t.e_tgt});
        @(posedge clk);
        #1;
        chk({name, ".valid"}, {31'b0, bp.pred_valid}, {31'b0, t.req});
        if (t.req) begin
            e = sb.pop_front();
            chk({name, ".taken"},  {31'b0, bp.pred_taken}, {31'b0, e.taken});
            chk({name, ".hit"},    {31'b0, bp.pred_hit},   {31'b0, e.hit});
            chk({name, ".target"}, bp.pred_target, e.tgt);
            last_exp = e;
        end else begin
            chk({name, ".hold_hit"},    {31'b0, bp.pred_hit}, {31'b0, last_exp.hit});
            chk({name, ".hold_target"}, bp.pred_target, last_exp.tgt);
        end
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        sb.delete();
        last_exp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int correct;

    initial begin
        last_exp = '0;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid",  {31'b0, bp.pred_valid}, 32'd0);
        chk("rst.target", bp.pred_target, 32'd0);
        chk("rst.perf_br", bp.perf_branches, 32'd0);
        chk("rst.perf_mis", bp.perf_mispredicts, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst");

`ifndef GSHARE_EN
        //        req ppc     uv upc     op ut utgt    upt  exp: tk hit tgt
        tbl.push_back(v(1, 32'h100, 0, 0,       0, 0, 0,       0, 0, 0, 32'h0));
        tbl.push_back(v(0, 0,       1, 32'h100, 1, 1, 32'h80,  0, 0, 0, 32'h0));
        tbl.push_back(v(0, 0,       1, 32'h100, 4, 1, 32'h80,  1, 0, 0, 32'h0));
        tbl.push_back(v(1, 32'h100, 0, 0,       0, 0, 0,       0, 1, 1, 32'h80));
        tbl.push_back(v(0, 0,       1, 32'h100, 5, 0, 0,       1, 0, 0, 32'h0));
        tbl.push_back(v(1, 32'h100, 0, 0,       0, 0, 0,       0, 1, 1, 32'h80));
        tbl.push_back(v(0, 0,       1, 32'h100, 0, 0, 0,       1, 0, 0, 32'h0));
        tbl.push_back(v(1, 32'h100, 0, 0,       0, 0, 0,       0, 0, 1, 32'h80));
        tbl.push_back(v(1, 32'h200, 1, 32'h200, 0, 1, 32'h300, 0, 1, 1, 32'h300));
        tbl.push_back(v(0, 0,       1, 32'h100, 6, 1, 32'h80,  1, 0, 0, 32'h0));
        tbl.push_back(v(0, 0,       1, 32'h200, 7, 1, 32'h40,  1, 0, 0, 32'h0));
        tbl.push_back(v(1, 32'h100, 0, 0,       0, 0, 0,       0, 0, 0, 32'h0));
        tbl.push_back(v(1, 32'h200, 0, 0,       0, 0, 0,       0, 1, 1, 32'h40));
        tbl.push_back(v(1, 32'h200, 1, 32'h200, 2, 1, 32'h500, 0, 1, 1, 32'h40));
        tbl.push_back(v(1, 32'h100, 1, 32'h100, 3, 1, 32'h600, 0, 0, 0, 32'h0));
        tbl.push_back(v(0, 0,       1, 32'h200, 1, 0, 0,       1, 0, 0, 32'h0));
        tbl.push_back(v(1, 32'h200, 0, 0,       0, 0, 0,       0, 1, 1, 32'h40));
        tbl.push_back(v(0, 0,       0, 0,       0, 0, 0,       0, 0, 0, 32'h0));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end
        chk("tbl.perf_br",  bp.perf_branches,    32'd8);
        chk("tbl.perf_mis", bp.perf_mispredicts, 32'd5);
`endif

        // Asynchronous reset in the middle of an outstanding request.
        step(v(1, 32'h300, 1, 32'h300, 0, 1, 32'h3C0, 0, 1, 1, 32'h3C0), "pre_rst");
        bp.pred_req = 1'b1;
        bp.pred_pc  = 32'h300;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.valid",  {31'b0, bp.pred_valid}, 32'd0);
        chk("midrst.taken",  {31'b0, bp.pred_taken}, 32'd0);
        chk("midrst.hit",    {31'b0, bp.pred_hit},   32'd0);
        chk("midrst.target", bp.pred_target, 32'd0);
        chk("midrst.perf",   bp.perf_branches, 32'd0);
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        last_exp = '0;
        step(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rel");
        step(v(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0), "rel_btb");
        step(v(0, 0, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0), "rel_n");
        step(v(0, 0, 1, 32'h300, 0, 1, 32'h44, 0, 0, 0, 0), "rel_t");
        step(v(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 1, 32'h44), "rel_bht");

        // Illegal funct3 is invisible to the counters; 10 legal updates with 3 mispredicts.
        do_reset();
        step(v(0, 0, 1, 32'h500, 2, 1, 32'h10, 0, 0, 0, 0), "illegal");
        chk("illegal.perf_br",  bp.perf_branches,    32'd0);
        chk("illegal.perf_mis", bp.perf_mispredicts, 32'd0);
        for (int i = 0; i < 10; i++) begin
            logic t;
            t = i[0];
            step(v(0, 0, 1, 32'h500 + 32'(i * 4), 1, t, 32'h20, (i < 3) ? !t : t, 0, 0, 0),
                 $sformatf("perf%0d", i));
        end
        chk("perf.branches",    bp.perf_branches,    32'd10);
        chk("perf.mispredicts", bp.perf_mispredicts, 32'd3);

`ifdef GSHARE_EN
        // Alternating T,N on one branch must be learned through global history.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step(v(0, 0, 1, 32'h400, 0, (k % 2) == 0, 32'h480, 0, 0, 0, 0), $sformatf("gtrain%0d", k));
        end
        correct = 0;
        for (int k = 16; k < 36; k++) begin
            logic actual;
            actual = (k % 2) == 0;
            bp.pred_req = 1'b1;
            bp.pred_pc  = 32'h400;
            @(posedge clk);
            #1;
            idle();
            if (bp.pred_valid && (bp.pred_taken == actual)) correct++;
            bp.upd_valid      = 1'b1;
            bp.upd_pc         = 32'h400;
            bp.upd_taken      = actual;
            bp.upd_target     = 32'h480;
            bp.upd_pred_taken = bp.pred_taken;
            @(posedge clk);
            #1;
            idle();
        end
        chk("gshare.correct", 32'(correct), 32'd20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
